// File: rtl/rv2t_fetch_unit.sv
// RV2T instruction fetch stage: owns the architectural PC, issues one instruction read at a time,
// and hands IR/PC to decode with a one-cycle enable_out strobe.
module rv2t_fetch_unit #(
  parameter int unsigned                 XLEN         = 32,
  parameter int unsigned                 PC_BITWIDTH  = 32,
  parameter logic [PC_BITWIDTH-1:0]      RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_reset,
  input  logic                   fetch_enable,
  input  logic                   jump_pc_en,
  input  logic [PC_BITWIDTH-1:0] jump_pc,
  output logic                   mem_read_req,
  output logic [PC_BITWIDTH-1:0] mem_read_addr,
  input  logic                   mem_read_ack,
  input  logic [XLEN-1:0]        mem_read_data,
  output logic [XLEN-1:0]        IR_out,
  output logic [PC_BITWIDTH-1:0] PC_out,
  output logic                   enable_out,
  output logic                   busy,
  output logic                   exception_instruction_addr_misaligned,
  output logic                   state_dbg
);

  // Memory handshake: mem_read_req is a one-cycle strobe with mem_read_addr held until the
  // matching mem_read_ack, which arrives at least one cycle later with mem_read_data valid.
  // Only one read is ever outstanding, so req is never raised again before that ack.

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic                     discard_q;
  logic [PC_BITWIDTH-1:0]   pc_q;
  logic [PC_BITWIDTH-1:0]   jump_target;
  logic [PC_BITWIDTH-1:0]   issue_addr;
  logic                     accept;
  logic                     issue;

  assign jump_target = {jump_pc[PC_BITWIDTH-1:2], 2'b00};
  assign issue_addr  = jump_pc_en ? jump_target : pc_q;

  // A response is only delivered when it belongs to the current PC stream.
  assign accept = (state_q == WAIT_ACK) && mem_read_ack && !discard_q && !jump_pc_en;

  // New reads come from a fetch in IDLE or from re-issuing after a dropped (stale) response.
  assign issue = ((state_q == IDLE) && fetch_enable) ||
                 ((state_q == WAIT_ACK) && mem_read_ack && (discard_q || jump_pc_en));

  assign busy      = (state_q == WAIT_ACK);
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else if (sync_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (fetch_enable) state_d = WAIT_ACK;
      WAIT_ACK: if (accept)       state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q                                  <= RESET_VECTOR;
      discard_q                             <= 1'b0;
      mem_read_req                          <= 1'b0;
      mem_read_addr                         <= RESET_VECTOR;
      IR_out                                <= '0;
      PC_out                                <= '0;
      enable_out                            <= 1'b0;
      exception_instruction_addr_misaligned <= 1'b0;
    end else if (sync_reset) begin
      pc_q                                  <= RESET_VECTOR;
      discard_q                             <= 1'b0;
      mem_read_req                          <= 1'b0;
      mem_read_addr                         <= RESET_VECTOR;
      IR_out                                <= '0;
      PC_out                                <= '0;
      enable_out                            <= 1'b0;
      exception_instruction_addr_misaligned <= 1'b0;
    end else begin
      mem_read_req                          <= issue;
      enable_out                            <= accept;
      exception_instruction_addr_misaligned <= jump_pc_en && (jump_pc[1:0] != 2'b00);

      if (issue) mem_read_addr <= issue_addr;

      if (jump_pc_en)  pc_q <= jump_target;
      else if (accept) pc_q <= pc_q + PC_BITWIDTH'(4);

      if (accept) begin
        IR_out <= mem_read_data;
        PC_out <= mem_read_addr;
      end

      // A redirect while waiting marks the in-flight response stale; any ack clears the mark.
      if (state_q == WAIT_ACK) begin
        if (mem_read_ack)    discard_q <= 1'b0;
        else if (jump_pc_en) discard_q <= 1'b1;
      end else begin
        discard_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv2t_fetch_unit.sv
// Self-checking bench for rv2t_fetch_unit: a simple memory responder plus a scoreboard of
// expected {IR, PC} pairs that is drained whenever decode would see enable_out.
module tb_rv2t_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        sync_reset;
  logic        fetch_enable;
  logic        jump_pc_en;
  logic [31:0] jump_pc;
  logic        mem_read_req;
  logic [31:0] mem_read_addr;
  logic        mem_read_ack;
  logic [31:0] mem_read_data;
  logic [31:0] IR_out;
  logic [31:0] PC_out;
  logic        enable_out;
  logic        busy;
  logic        exc;
  logic        state_dbg;

  int checks = 0;
  int passed = 0;
  int en_count = 0;
  bit req_prev = 0;
  logic [63:0] exp_q[$];

  rv2t_fetch_unit #(.XLEN(32), .PC_BITWIDTH(32), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
    .fetch_enable(fetch_enable), .jump_pc_en(jump_pc_en), .jump_pc(jump_pc),
    .mem_read_req(mem_read_req), .mem_read_addr(mem_read_addr),
    .mem_read_ack(mem_read_ack), .mem_read_data(mem_read_data),
    .IR_out(IR_out), .PC_out(PC_out), .enable_out(enable_out), .busy(busy),
    .exception_instruction_addr_misaligned(exc), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor and request-spacing check
  always @(negedge clk) begin
    if (mem_read_req) begin
      checks++;
      if (req_prev) $display("FAIL req_back_to_back: req high two cycles in a row, addr=%h", mem_read_addr);
      else passed++;
    end
    req_prev = mem_read_req;
    if (enable_out) begin
      logic [63:0] e;
      en_count++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_enable: IR=%h PC=%h with no expected response", IR_out, PC_out);
      end else begin
        e = exp_q.pop_front();
        if (IR_out !== e[63:32] || PC_out !== e[31:0])
          $display("FAIL decode_out: got IR=%h PC=%h, expected IR=%h PC=%h", IR_out, PC_out, e[63:32], e[31:0]);
        else passed++;
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_fetch();
    fetch_enable = 1'b1;
    cyc();
    fetch_enable = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    jump_pc_en = 1'b1;
    jump_pc    = target;
    cyc();
    jump_pc_en = 1'b0;
  endtask

  task automatic wait_req(output bit found, output logic [31:0] a);
    found = 1'b0;
    a = '0;
    for (int i = 0; i < 20; i++) begin
      if (mem_read_req) begin
        found = 1'b1;
        a = mem_read_addr;
        break;
      end
      cyc();
    end
  endtask

  task automatic send_ack(input logic [31:0] d, input int lat);
    repeat (lat) cyc();
    mem_read_ack  = 1'b1;
    mem_read_data = d;
    cyc();
    mem_read_ack  = 1'b0;
  endtask

  // fetch, expect a request at exp_addr, answer it and queue the expected decode output
  task automatic fetch_serve(input logic [31:0] exp_addr, input logic [31:0] d, input int lat,
                             output bit found, output logic [31:0] a);
    pulse_fetch();
    wait_req(found, a);
    exp_q.push_back({d, exp_addr});
    send_ack(d, lat);
  endtask

  // tests
  task automatic test_reset();
    reset_n = 1'b0; sync_reset = 1'b0; fetch_enable = 1'b0; jump_pc_en = 1'b0;
    jump_pc = '0; mem_read_ack = 1'b0; mem_read_data = '0;
    cyc();
    checks++;
    if (mem_read_req !== 1'b0 || mem_read_addr !== 32'h0 || enable_out !== 1'b0)
      $display("FAIL reset_mem: req=%b addr=%h en=%b, expected 0/0/0", mem_read_req, mem_read_addr, enable_out);
    else passed++;
    checks++;
    if (IR_out !== 32'h0 || PC_out !== 32'h0)
      $display("FAIL reset_ir_pc: IR=%h PC=%h, expected 0/0", IR_out, PC_out);
    else passed++;
    checks++;
    if (busy !== 1'b0 || exc !== 1'b0 || state_dbg !== 1'b0)
      $display("FAIL reset_status: busy=%b exc=%b state=%b, expected 0/0/0", busy, exc, state_dbg);
    else passed++;
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic_fetch();
    bit f; logic [31:0] a;
    pulse_fetch();
    wait_req(f, a);
    checks++;
    if (!f || a !== 32'h0) $display("FAIL basic_addr: found=%b addr=%h, expected addr 00000000", f, a);
    else passed++;
    checks++;
    if (busy !== 1'b1) $display("FAIL basic_busy: busy=%b, expected 1", busy);
    else passed++;
    exp_q.push_back({32'h00000013, 32'h0});
    send_ack(32'h00000013, 2);
    checks++;
    if (busy !== 1'b0 || enable_out !== 1'b1) $display("FAIL basic_done: busy=%b en=%b, expected 0/1", busy, enable_out);
    else passed++;
    cyc();
    checks++;
    if (enable_out !== 1'b0) $display("FAIL basic_strobe_len: en=%b, expected 0", enable_out);
    else passed++;
    fetch_serve(32'h4, 32'h00200113, 1, f, a);
    checks++;
    if (!f || a !== 32'h4) $display("FAIL basic_next_addr: found=%b addr=%h, expected 00000004", f, a);
    else passed++;
    cyc();
  endtask

  task automatic test_redirect_wait();
    bit f; logic [31:0] a;
    pulse_fetch();
    wait_req(f, a);
    checks++;
    if (!f || a !== 32'h8) $display("FAIL redir_first_addr: found=%b addr=%h, expected 00000008", f, a);
    else passed++;
    redirect(32'h100);
    checks++;
    if (exc !== 1'b0 || busy !== 1'b1 || mem_read_addr !== 32'h8)
      $display("FAIL redir_hold: exc=%b busy=%b addr=%h, expected 0/1/00000008", exc, busy, mem_read_addr);
    else passed++;
    send_ack(32'h0000DEAD, 1);
    wait_req(f, a);
    checks++;
    if (!f || a !== 32'h100) $display("FAIL redir_reissue: found=%b addr=%h, expected 00000100", f, a);
    else passed++;
    exp_q.push_back({32'h00100093, 32'h100});
    send_ack(32'h00100093, 2);
    cyc();
  endtask

  task automatic test_redirect_same_ack();
    bit f; logic [31:0] a; int en0;
    en0 = en_count;
    pulse_fetch();
    wait_req(f, a);
    checks++;
    if (!f || a !== 32'h104) $display("FAIL same_first_addr: found=%b addr=%h, expected 00000104", f, a);
    else passed++;
    cyc();
    mem_read_ack = 1'b1; mem_read_data = 32'h00000BAD;
    jump_pc_en = 1'b1; jump_pc = 32'h200;
    cyc();
    mem_read_ack = 1'b0; jump_pc_en = 1'b0;
    checks++;
    if (!mem_read_req || mem_read_addr !== 32'h200)
      $display("FAIL same_reissue: req=%b addr=%h, expected 1/00000200", mem_read_req, mem_read_addr);
    else passed++;
    exp_q.push_back({32'h00A00513, 32'h200});
    send_ack(32'h00A00513, 3);
    repeat (3) cyc();
    checks++;
    if (en_count - en0 !== 1) $display("FAIL same_enable_count: got %0d strobes, expected 1", en_count - en0);
    else passed++;
  endtask

  task automatic test_misaligned();
    bit f; logic [31:0] a;
    redirect(32'h102);
    checks++;
    if (exc !== 1'b1) $display("FAIL misal_strobe: exc=%b, expected 1", exc);
    else passed++;
    cyc();
    checks++;
    if (exc !== 1'b0 || mem_read_req !== 1'b0) $display("FAIL misal_clear: exc=%b req=%b, expected 0/0", exc, mem_read_req);
    else passed++;
    fetch_serve(32'h100, 32'h00000033, 1, f, a);
    checks++;
    if (!f || a !== 32'h100) $display("FAIL misal_pc: found=%b addr=%h, expected 00000100", f, a);
    else passed++;
    cyc();
  endtask

  task automatic test_redirect_fetch_idle();
    bit f; logic [31:0] a;
    jump_pc_en = 1'b1; jump_pc = 32'h300;
    pulse_fetch();
    jump_pc_en = 1'b0;
    wait_req(f, a);
    checks++;
    if (!f || a !== 32'h300) $display("FAIL idle_jump_fetch: found=%b addr=%h, expected 00000300", f, a);
    else passed++;
    exp_q.push_back({32'h12345678, 32'h300});
    send_ack(32'h12345678, 1);
    cyc();
  endtask

  task automatic test_wrap();
    bit f; logic [31:0] a;
    redirect(32'hFFFFFFFC);
    fetch_serve(32'hFFFFFFFC, 32'hCAFEF00D, 2, f, a);
    checks++;
    if (!f || a !== 32'hFFFFFFFC) $display("FAIL wrap_top: found=%b addr=%h, expected FFFFFFFC", f, a);
    else passed++;
    cyc();
    fetch_serve(32'h0, 32'h00000073, 1, f, a);
    checks++;
    if (!f || a !== 32'h0) $display("FAIL wrap_zero: found=%b addr=%h, expected 00000000", f, a);
    else passed++;
    cyc();
  endtask

  task automatic test_async_reset();
    bit f; logic [31:0] a; int en0;
    en0 = en_count;
    pulse_fetch();
    wait_req(f, a);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_read_req !== 1'b0 || mem_read_addr !== 32'h0)
      $display("FAIL areset_now: busy=%b req=%b addr=%h, expected 0/0/00000000", busy, mem_read_req, mem_read_addr);
    else passed++;
    cyc();
    reset_n = 1'b1;
    send_ack(32'h0000BEEF, 1);
    repeat (2) cyc();
    checks++;
    if (en_count != en0 || busy !== 1'b0)
      $display("FAIL areset_late_ack: strobes=%0d busy=%b, expected 0/0", en_count - en0, busy);
    else passed++;
    fetch_serve(32'h0, 32'h00400213, 1, f, a);
    checks++;
    if (!f || a !== 32'h0) $display("FAIL areset_pc: found=%b addr=%h, expected 00000000", f, a);
    else passed++;
    cyc();
  endtask

  task automatic test_sync_reset();
    bit f; logic [31:0] a; int en0;
    en0 = en_count;
    pulse_fetch();
    wait_req(f, a);
    sync_reset = 1'b1;
    cyc();
    sync_reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || IR_out !== 32'h0 || PC_out !== 32'h0)
      $display("FAIL sreset_state: busy=%b IR=%h PC=%h, expected 0/0/0", busy, IR_out, PC_out);
    else passed++;
    send_ack(32'h0000BEEF, 1);
    cyc();
    checks++;
    if (en_count != en0) $display("FAIL sreset_late_ack: strobes=%0d, expected 0", en_count - en0);
    else passed++;
    fetch_serve(32'h0, 32'h00500293, 2, f, a);
    checks++;
    if (!f || a !== 32'h0) $display("FAIL sreset_pc: found=%b addr=%h, expected 00000000", f, a);
    else passed++;
    cyc();
  endtask

  task automatic test_back_to_back();
    bit f; logic [31:0] a; logic [31:0] pc; logic [31:0] d;
    pc = 32'h4;
    for (int i = 0; i < 8; i++) begin
      d = $urandom();
      fetch_serve(pc, d, $urandom_range(1, 4), f, a);
      checks++;
      if (!f || a !== pc) $display("FAIL b2b_addr[%0d]: found=%b addr=%h, expected %h", i, f, a, pc);
      else passed++;
      pc = pc + 32'h4;
    end
    repeat (2) cyc();
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_redirect_wait();
    test_redirect_same_ack();
    test_misaligned();
    test_redirect_fetch_idle();
    test_wrap();
    test_async_reset();
    test_sync_reset();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d responses never delivered, expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
